// File: rtl/control_pkg.sv
// Shared definitions for the multicycle main controller.
// Holds the FSM state enum, instruction-field codes (Op, cmd) and the
// datapath select encodings driven by control_fsm and alu_decoder.
package control_pkg;

  // Width of the state enum; 11 states fit in 4 bits.
  localparam int unsigned STATE_ENC_W = 4;

  typedef enum logic [STATE_ENC_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_t;

  // Op field, instr[27:26]; 2'b11 is undefined.
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // cmd field, instr[24:21]
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [1:0] SRCA_REG    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

endpackage

// File: rtl/control_fsm_alu_decoder.sv
// Combinational ALU decoder.
// Ports: ALUOp (execute-phase enable), Funct (I, cmd[3:0], S) in;
//        ALUControl (ALU operation) and FlagW ([1] N/Z, [0] C/V write) out.
module alu_decoder
  import control_pkg::*;
(
  input  logic       ALUOp,
  input  logic [5:0] Funct,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW
);

  logic [3:0] cmd;
  logic       s_bit;
  logic       arith;
  logic       valid;
  logic       unused_imm;

  assign cmd        = Funct[4:1];
  assign s_bit      = Funct[0];
  assign unused_imm = Funct[5];

  always_comb begin
    ALUControl = ALU_ADD;
    FlagW      = '0;
    arith      = 1'b0;
    valid      = 1'b1;
    if (ALUOp) begin
      unique case (cmd)
        CMD_ADD: begin ALUControl = ALU_ADD; arith = 1'b1; end
        CMD_SUB: begin ALUControl = ALU_SUB; arith = 1'b1; end
        CMD_AND: ALUControl = ALU_AND;
        CMD_ORR: ALUControl = ALU_ORR;
        CMD_CMP: begin ALUControl = ALU_SUB; arith = 1'b1; end
        default: valid = 1'b0;
      endcase
      if (valid) begin
        FlagW[1] = s_bit;
        FlagW[0] = s_bit & arith;
      end
    end
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle main controller and instruction decoder (Moore FSM).
// Ports: clk, reset (sync, active-high); Op, Funct, Rd instruction fields in.
// Outputs: datapath selects (IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
// ALUControl) and the conditional-logic bundle (FlagW, PCS, NextPC, RegW,
// MemW, noWrite) plus a one-cycle IllegalOp pulse for undefined Op.
module control_fsm
  import control_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       noWrite,
  output logic       IllegalOp
);

  logic [STATE_W-1:0] state_q, state_d;
  state_t             cur_state, nxt_state;
  logic               alu_op;
  logic               branch;

  // Encodings outside the enum fall into the case default and return to FETCH.
  assign cur_state = state_t'(state_q[STATE_ENC_W-1:0]);

  always_ff @(posedge clk) begin
    if (reset) state_q <= STATE_W'(S_FETCH);
    else       state_q <= state_d;
  end

  always_comb begin
    nxt_state = S_FETCH;
    unique case (cur_state)
      S_FETCH:  nxt_state = S_DECODE;
      S_DECODE: begin
        unique case (Op)
          OP_MEM:  nxt_state = S_MEMADR;
          OP_DP:   nxt_state = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   nxt_state = S_BRANCH;
          default: nxt_state = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   nxt_state = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  nxt_state = S_MEMWB;
      S_EXECUTER: nxt_state = S_ALUWB;
      S_EXECUTEI: nxt_state = S_ALUWB;
      default:    nxt_state = S_FETCH;
    endcase
    state_d = STATE_W'(nxt_state);
  end

  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_REG;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    RegW      = 1'b0;
    MemW      = 1'b0;
    IllegalOp = 1'b0;
    alu_op    = 1'b0;
    branch    = 1'b0;
    unique case (cur_state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_MEMADR:   ALUSrcB = SRCB_IMM;
      S_MEMREAD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_EXECUTER: alu_op = 1'b1;
      S_EXECUTEI: begin
        ALUSrcB = SRCB_IMM;
        alu_op  = 1'b1;
      end
      S_ALUWB:    RegW = 1'b1;
      S_BRANCH: begin
        ALUSrcA   = SRCA_ALUOUT;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        branch    = 1'b1;
      end
      S_UNKNOWN:  IllegalOp = 1'b1;
      default: ;
    endcase
    // Reset masks every enable and presents the FETCH selects, whatever the
    // state register currently holds.
    if (reset) begin
      IRWrite   = 1'b0;
      NextPC    = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_FOUR;
      ResultSrc = RES_ALURESULT;
      RegW      = 1'b0;
      MemW      = 1'b0;
      IllegalOp = 1'b0;
      alu_op    = 1'b0;
      branch    = 1'b0;
    end
  end

  assign noWrite = (Op == OP_DP) && (Funct[4:1] == CMD_CMP);
  assign PCS     = branch | (RegW & (Rd == 4'hF) & ~noWrite);

  alu_decoder u_alu_decoder (
    .ALUOp      (alu_op),
    .Funct      (Funct),
    .ALUControl (ALUControl),
    .FlagW      (FlagW)
  );

endmodule
